// File: rtl/s641_bist_ctrl.sv
// BIST sequencer for the s641 core: flush, LFSR-driven capture into a MISR, golden compare.
// Optional S641_BIST_STEP_EN adds a STEP input that gates RUN-phase advancement.
module s641_bist_ctrl #(
    parameter int unsigned     PI_W       = 35,
    parameter int unsigned     PO_W       = 24,
    parameter int unsigned     N_PATTERNS = 256,
    parameter int unsigned     FLUSH_CYC  = 20,
    parameter logic [PI_W-1:0] SEED       = 35'h000000001,
    parameter logic [PO_W-1:0] GOLDEN_SIG = 24'h000000
) (
    input  logic            CK,
    input  logic            RST,
    input  logic            START,
`ifdef S641_BIST_STEP_EN
    input  logic            STEP,
`endif
    input  logic [PO_W-1:0] DUT_PO,
    output logic [PI_W-1:0] DUT_PI,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [PO_W-1:0] SIGNATURE
);

    localparam logic [PI_W-1:0] SEED_EFF   = (SEED == '0) ? PI_W'(1) : SEED;
    localparam logic [PI_W-1:0] LFSR_TAPS  = PI_W'(35'h200000001);
    localparam logic [PO_W-1:0] MISR_TAPS  = PO_W'(24'hC20001);
    localparam logic [15:0]     FLUSH_LAST = 16'(FLUSH_CYC - 1);
    localparam logic [15:0]     RUN_LAST   = 16'(N_PATTERNS - 1);

    typedef enum logic [2:0] {StIdle, StFlush, StRun, StCmp, StDone} state_e;

    state_e          state_q, state_d;
    logic [PI_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [PO_W-1:0] misr_q, misr_d, misr_nxt;
    logic [15:0]     cnt_q, cnt_d;
    logic [PI_W-1:0] pi_q, pi_d;
    logic            pass_q, pass_d;
    logic            advance;

`ifdef S641_BIST_STEP_EN
    assign advance = STEP;
`else
    assign advance = 1'b1;
`endif

    assign lfsr_nxt = {lfsr_q[PI_W-2:0], 1'b0} ^ (lfsr_q[PI_W-1] ? LFSR_TAPS : '0);
    assign misr_nxt = {misr_q[PO_W-2:0], 1'b0} ^ (misr_q[PO_W-1] ? MISR_TAPS : '0) ^ DUT_PO;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pi_d    = pi_q;
        pass_d  = pass_q;
        case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                    misr_d  = '0;
                    lfsr_d  = SEED_EFF;
                    pi_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            StFlush: begin
                // cnt doubles as the flush counter, then restarts for the capture count
                if (cnt_q == FLUSH_LAST) begin
                    pi_d    = lfsr_q;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun: begin
                if (advance) begin
                    misr_d = misr_nxt;
                    lfsr_d = lfsr_nxt;
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q == RUN_LAST) begin
                        pi_d    = '0;
                        state_d = StCmp;
                    end else begin
                        pi_d = lfsr_nxt;
                    end
                end
            end
            StCmp: begin
                pass_d  = (misr_q == GOLDEN_SIG);
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            lfsr_q  <= SEED_EFF;
            misr_q  <= '0;
            cnt_q   <= '0;
            pi_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            pass_q  <= pass_d;
        end
    end

    assign DUT_PI    = pi_q;
    assign BUSY      = (state_q == StFlush) || (state_q == StRun) || (state_q == StCmp);
    assign DONE      = (state_q == StDone);
    assign PASS      = pass_q;
    assign SIGNATURE = misr_q;

endmodule
